// File: rtl/if_id_hazard_ctrl_if.sv
// if_id_hazard_ctrl_if: hazard sources into the IF/ID controller and its PC/IF/ID/ID-EX controls out
interface if_id_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       imem_ready;
  logic       dmem_busy;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_bubble;
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, imem_ready, dmem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, imem_ready, dmem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble
  );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl: sequences PC/IF-ID from redirect, memory and load-use hazards, with saturating counters
module if_id_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  if_id_hazard_ctrl_if.slave   hz,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);
  typedef enum logic [1:0] {RUN, FLUSH, WAIT_MEM} state_t;
  state_t     state, state_nxt, eff;
  logic [3:0] fcnt, fcnt_nxt;
  logic       pend, pend_nxt, load_use;
  logic       pc_c, en_c, fl_c, bub_c;
  // WAIT_MEM resolves to the state it froze, so the exit cycle follows normal priority
  always_comb begin
    eff       = (state == WAIT_MEM) ? (pend ? FLUSH : RUN) : state;
    load_use  = hz.ex_mem_read && hz.ex_rd != 5'd0 &&
                ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
    pc_c      = 1'b1;
    en_c      = 1'b1;
    fl_c      = 1'b0;
    bub_c     = 1'b0;
    state_nxt = eff;
    fcnt_nxt  = fcnt;
    pend_nxt  = 1'b0;
    if (hz.ex_redirect) begin
      fl_c      = 1'b1;
      bub_c     = 1'b1;
      state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      fcnt_nxt  = 4'(FLUSH_CYCLES - 1);
    end else if (hz.dmem_busy) begin
      pc_c      = 1'b0;
      en_c      = 1'b0;
      state_nxt = WAIT_MEM;
      pend_nxt  = (eff == FLUSH);
    end else if (eff == RUN && load_use) begin
      pc_c      = 1'b0;
      en_c      = 1'b0;
      bub_c     = 1'b1;
    end else if (eff == FLUSH) begin
      fl_c      = 1'b1;
      pc_c      = hz.imem_ready;
      fcnt_nxt  = (hz.imem_ready && fcnt != 4'd0) ? fcnt - 4'd1 : fcnt;
      state_nxt = (hz.imem_ready && fcnt <= 4'd1) ? RUN : FLUSH;
    end else if (!hz.imem_ready) begin
      pc_c      = 1'b0;
      fl_c      = 1'b1;
    end
  end
  assign hz.pc_en        = reset & pc_c;
  assign hz.if_id_en     = reset & en_c;
  assign hz.if_id_flush  = ~reset | fl_c;
  assign hz.id_ex_bubble = ~reset | bub_c;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      fcnt        <= 4'd0;
      pend        <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      pend  <= pend_nxt;
      if (!pc_c && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
      if (fl_c && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb_if_id_hazard_ctrl: directed checks of the IF/ID hazard controller with FLUSH_CYCLES=3
module tb_if_id_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] stall_count, flush_count;
  int          n_chk = 0;
  int          n_fail = 0;
  if_id_hazard_ctrl_if hz();
  if_id_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hz(hz), .stall_count(stall_count), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = 5'd0; hz.ex_redirect = 1'b0;
    hz.imem_ready = 1'b1; hz.dmem_busy = 1'b0;
  endtask
  task automatic lu(input logic [4:0] rd);
    hz.ex_mem_read = 1'b1; hz.ex_rd = rd; hz.id_rs2 = 5'd5; hz.id_uses_rs2 = 1'b1;
  endtask
  // exp = {pc_en, if_id_en, if_id_flush, id_ex_bubble}, sampled mid-cycle, then advance one edge
  task automatic step(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_bubble}, exp);
    @(posedge clk); #1;
  endtask
  task automatic cnt(input string tag, input logic [15:0] s, input logic [15:0] f);
    chk({tag, "_stall"}, stall_count, s);
    chk({tag, "_flush"}, flush_count, f);
  endtask
  initial begin
    idle();
    #2 reset = 1'b0;
    step("in_reset", 4'b0011);
    cnt("in_reset", 16'd0, 16'd0);
    step("in_reset2", 4'b0011);
    step("in_reset3", 4'b0011);
    reset = 1'b1;
    step("run", 4'b1100);
    cnt("run", 16'd0, 16'd0);
    lu(5'd5);
    step("lu_rs2", 4'b0001);
    idle();
    cnt("lu_rs2", 16'd1, 16'd0);
    step("lu_after", 4'b1100);
    lu(5'd0);
    hz.id_rs2 = 5'd0; hz.id_uses_rs1 = 1'b1;
    step("lu_x0", 4'b1100);
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_uses_rs1 = 1'b1;
    step("lu_rs1", 4'b0001);
    hz.id_uses_rs1 = 1'b0;
    step("lu_nouse", 4'b1100);
    idle();
    cnt("lu", 16'd2, 16'd0);
    hz.ex_redirect = 1'b1;
    step("redir", 4'b1111);
    idle();
    step("fl1", 4'b1110);
    step("fl2", 4'b1110);
    step("fl_end", 4'b1100);
    cnt("redir", 16'd2, 16'd3);
    hz.ex_redirect = 1'b1;
    step("r2a", 4'b1111);
    step("r2b", 4'b1111);
    idle();
    step("r2_fl1", 4'b1110);
    step("r2_fl2", 4'b1110);
    step("r2_end", 4'b1100);
    cnt("redir2", 16'd2, 16'd7);
    hz.ex_redirect = 1'b1;
    step("mb_redir", 4'b1111);
    idle();
    step("mb_fl", 4'b1110);
    hz.dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) step("mb_freeze", 4'b0000);
    hz.dmem_busy = 1'b0;
    step("mb_resume", 4'b1110);
    step("mb_run", 4'b1100);
    cnt("membusy", 16'd6, 16'd10);
    lu(5'd5);
    hz.ex_redirect = 1'b1; hz.dmem_busy = 1'b1;
    step("simul", 4'b1111);
    idle();
    step("simul_fl1", 4'b1110);
    step("simul_fl2", 4'b1110);
    step("simul_end", 4'b1100);
    cnt("simul", 16'd6, 16'd13);
    lu(5'd5);
    hz.dmem_busy = 1'b1;
    step("wm_busy", 4'b0000);
    hz.dmem_busy = 1'b0;
    step("wm_exit_lu", 4'b0001);
    idle();
    step("wm_run", 4'b1100);
    cnt("wm", 16'd8, 16'd13);
    hz.ex_redirect = 1'b1;
    step("ir_redir", 4'b1111);
    idle();
    hz.imem_ready = 1'b0;
    step("ir_wait", 4'b0110);
    hz.imem_ready = 1'b1;
    step("ir_fl1", 4'b1110);
    step("ir_fl2", 4'b1110);
    step("ir_end", 4'b1100);
    cnt("imem_fl", 16'd9, 16'd17);
    hz.ex_redirect = 1'b1;
    step("rm_redir", 4'b1111);
    idle();
    reset = 1'b0;
    step("rm_reset", 4'b0011);
    reset = 1'b1;
    step("rm_run", 4'b1100);
    cnt("rm", 16'd0, 16'd0);
    hz.imem_ready = 1'b0;
    step("sat_out", 4'b0110);
    repeat (70000) @(posedge clk);
    #1;
    cnt("sat", 16'hFFFF, 16'hFFFF);
    step("sat_hold", 4'b0110);
    cnt("sat_hold", 16'hFFFF, 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
